// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by hazard_ctrl and hazard_fwd_sel.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// E-stage operand forwarding select for one source register.
// The M stage is newer than W, so it takes priority.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] Fwd
);

  // Pick the youngest in-flight producer of RsE; x0 is never forwarded.
  always_comb begin
    Fwd = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
      Fwd = FWD_M;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
      Fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forward control with data-memory wait FSM.
// ERR is sticky until reset and keeps the whole pipeline frozen.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        dmem_ready,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  localparam int CW = $clog2(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   stall_cycles_q;
  logic          mem_stall;
  logic          lw_stall;

  hazard_fwd_sel u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Fwd       (ForwardAE)
  );

  hazard_fwd_sel u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Fwd       (ForwardBE)
  );

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory-wait FSM: next state, wait counter and memory stall.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    unique case (state_q)
      RUN: begin
        mem_stall = MemReqM && !dmem_ready;
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      MEM_WAIT: begin
        mem_stall = !dmem_ready;
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // A flush is suppressed while frozen so a held branch retries it later.
  always_comb begin
    StallF = mem_stall || lw_stall;
    StallD = mem_stall || lw_stall;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushW = mem_stall;
    FlushD = PCSrcE && !mem_stall;
    FlushE = (lw_stall || PCSrcE) && !mem_stall;
  end

  // State, wait counter and saturating stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (StallF && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign mem_err      = (state_q == ERR);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int WM = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0;
  logic        PCSrcE, MemReqM, dmem_ready;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        mem_err;
  logic [31:0] stall_cycles;
  logic [6:0]  ctl;

  int n_pass;
  int n_total;

  hazard_ctrl #(.WAIT_MAX(WM)) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .ResultSrcE0  (ResultSrcE0),
    .PCSrcE       (PCSrcE),
    .MemReqM      (MemReqM),
    .dmem_ready   (dmem_ready),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
    RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0;
    PCSrcE = 0; MemReqM = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clr_inputs();
    MemReqM = 1'b1;
    #1;
    n_total++;
    if (stall_cycles !== 32'd0)
      $display("FAIL reset_cnt got %0d exp 0", stall_cycles);
    else n_pass++;
    n_total++;
    if (mem_err !== 1'b0)
      $display("FAIL reset_err got %b exp 0", mem_err);
    else n_pass++;
    n_total++;
    if (ctl !== 7'b1111001)
      $display("FAIL reset_ctl got %b exp 1111001", ctl);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    clr_inputs();
  endtask

  task automatic test_forwarding();
    do_reset();
    Rs1E = 5; Rs2E = 5; RdM = 5; RdW = 5;
    RegWriteM = 1; RegWriteW = 1;
    #1;
    n_total++;
    if ({ForwardAE, ForwardBE} !== 4'b1010)
      $display("FAIL fwd_m got %b exp 1010", {ForwardAE, ForwardBE});
    else n_pass++;
    RegWriteM = 0;
    #1;
    n_total++;
    if ({ForwardAE, ForwardBE} !== 4'b0101)
      $display("FAIL fwd_w got %b exp 0101", {ForwardAE, ForwardBE});
    else n_pass++;
    Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
    #1;
    n_total++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("FAIL fwd_x0 got %b exp 0000", {ForwardAE, ForwardBE});
    else n_pass++;
    Rs1E = 3; Rs2E = 9; RdM = 9; RdW = 3;
    #1;
    n_total++;
    if ({ForwardAE, ForwardBE} !== 4'b0110)
      $display("FAIL fwd_mix got %b exp 0110", {ForwardAE, ForwardBE});
    else n_pass++;
    clr_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; Rs1D = 2;
    #1;
    n_total++;
    if (ctl !== 7'b1100010)
      $display("FAIL loaduse got %b exp 1100010", ctl);
    else n_pass++;
    RdE = 0; Rs2D = 0;
    #1;
    n_total++;
    if (ctl !== 7'b0000000)
      $display("FAIL loaduse_x0 got %b exp 0000000", ctl);
    else n_pass++;
    clr_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    PCSrcE = 1;
    #1;
    n_total++;
    if (ctl !== 7'b0000110)
      $display("FAIL branch got %b exp 0000110", ctl);
    else n_pass++;
    @(negedge clk);
    PCSrcE = 0;
    #1;
    n_total++;
    if (ctl !== 7'b0000000)
      $display("FAIL branch_end got %b exp 0000000", ctl);
    else n_pass++;
    clr_inputs();
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (ctl !== 7'b1111001)
        $display("FAIL memwait_c%0d got %b exp 1111001", i, ctl);
      else n_pass++;
      @(negedge clk);
    end
    dmem_ready = 1;
    #1;
    n_total++;
    if (ctl !== 7'b0000110)
      $display("FAIL memwait_done got %b exp 0000110", ctl);
    else n_pass++;
    @(negedge clk);
    clr_inputs();
    #1;
    n_total++;
    if (stall_cycles !== 32'd3)
      $display("FAIL memwait_cnt got %0d exp 3", stall_cycles);
    else n_pass++;
    n_total++;
    if (ctl !== 7'b0000000)
      $display("FAIL memwait_idle got %b exp 0000000", ctl);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    MemReqM = 1;
    for (int i = 0; i < WM; i++) begin
      #1;
      n_total++;
      if ({mem_err, ctl} !== 8'b0_1111001)
        $display("FAIL tmo_c%0d got %b exp 01111001", i, {mem_err, ctl});
      else n_pass++;
      @(negedge clk);
    end
    MemReqM = 0; dmem_ready = 1; PCSrcE = 1;
    #1;
    n_total++;
    if ({mem_err, ctl} !== 8'b1_1111001)
      $display("FAIL tmo_err got %b exp 11111001", {mem_err, ctl});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({mem_err, ctl} !== 8'b1_1111001)
      $display("FAIL tmo_sticky got %b exp 11111001", {mem_err, ctl});
    else n_pass++;
    n_total++;
    if (stall_cycles !== 32'd5)
      $display("FAIL tmo_cnt got %0d exp 5", stall_cycles);
    else n_pass++;
    clr_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    MemReqM = 1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if ({mem_err, stall_cycles} !== 33'd0)
      $display("FAIL rstwait_regs got err=%b cnt=%0d exp 0/0",
               mem_err, stall_cycles);
    else n_pass++;
    MemReqM = 0;
    #1;
    n_total++;
    if (ctl !== 7'b0000000)
      $display("FAIL rstwait_run got %b exp 0000000", ctl);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    MemReqM = 1; dmem_ready = 1;
    #1;
    n_total++;
    if (ctl !== 7'b0000000)
      $display("FAIL rstwait_ready got %b exp 0000000", ctl);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (stall_cycles !== 32'd0)
      $display("FAIL rstwait_cnt got %0d exp 0", stall_cycles);
    else n_pass++;
    clr_inputs();
  endtask

  task automatic test_random();
    bit          m_err, m_waiting, ms, lw;
    int          m_waited;
    logic [31:0] m_cnt;
    logic [6:0]  e_ctl;
    do_reset();
    m_err = 0; m_waiting = 0; m_waited = 0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 249) begin
        do_reset();
        m_err = 0; m_waiting = 0; m_waited = 0; m_cnt = 0;
      end
      Rs1D = 5'($urandom_range(0, 7));
      Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7));
      Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7));
      RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      PCSrcE      = ($urandom_range(0, 3) == 0);
      MemReqM     = ($urandom_range(0, 2) == 0);
      dmem_ready  = ($urandom_range(0, 3) != 0);
      #1;
      lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (m_err) ms = 1;
      else if (m_waiting) ms = !dmem_ready;
      else ms = MemReqM && !dmem_ready;
      e_ctl = {ms | lw, ms | lw, ms, ms,
               PCSrcE & !ms, (lw | PCSrcE) & !ms, ms};
      n_total++;
      if (ctl !== e_ctl)
        $display("FAIL rnd_ctl c%0d got %b exp %b", c, ctl, e_ctl);
      else n_pass++;
      n_total++;
      if ({ForwardAE, ForwardBE} !== {ref_fwd(Rs1E), ref_fwd(Rs2E)})
        $display("FAIL rnd_fwd c%0d got %b exp %b", c,
                 {ForwardAE, ForwardBE}, {ref_fwd(Rs1E), ref_fwd(Rs2E)});
      else n_pass++;
      n_total++;
      if (mem_err !== m_err || stall_cycles !== m_cnt)
        $display("FAIL rnd_state c%0d got err=%b cnt=%0d exp err=%b cnt=%0d",
                 c, mem_err, stall_cycles, m_err, m_cnt);
      else n_pass++;
      if (ms || lw) m_cnt++;
      if (!m_err) begin
        if (ms) begin
          m_waited++;
          m_waiting = 1;
          if (m_waited == WM) m_err = 1;
        end else begin
          m_waiting = 0;
          m_waited  = 0;
        end
      end
      @(negedge clk);
    end
    clr_inputs();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    clr_inputs();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It drives the stall (enable) and clear inputs of the F/D, D/E, E/M and M/W pipeline registers and generates the E-stage forwarding selects. It also holds a small state machine that freezes the pipeline while the data memory inserts wait states, with a timeout that latches an error. It sits beside the datapath, fed by register indices and control bits from each stage.

## Interface
Parameters:
- WAIT_MAX, 16: maximum data-memory wait cycles before timeout; legal range 2..255.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers in D.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in E.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  write-enable in M and W.
- ResultSrcE0  in  1  E holds a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MemReqM  in  1  M holds a load or store.
- dmem_ready  in  1  data memory completes this cycle.
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALUResultM, 01 = ResultW.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding register.
- FlushD, FlushE, FlushW  out  1  clear the D, E and W registers (bubble).
- mem_err  out  1  sticky timeout flag.
- stall_cycles  out  32  saturating count of cycles with StallF=1.

## Operation
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Otherwise ForwardAE=00. ForwardBE follows the same rules with Rs2E.
  - M has priority over W.
- Load-use: lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall:
  - In RUN: MemReqM & !dmem_ready.
  - In MEM_WAIT: !dmem_ready.
  - In ERR: 1.
- Outputs:
  - StallF = StallD = memStall | lwStall.
  - StallE = StallM = FlushW = memStall.
  - FlushD = PCSrcE & !memStall.
  - FlushE = (lwStall | PCSrcE) & !memStall.
- A branch resolved during a memory stall stays held in E. Its flush is applied in the first cycle memStall drops.
- FSM (states RUN, MEM_WAIT, ERR):
  - RUN to MEM_WAIT on MemReqM & !dmem_ready; wait_cnt loads 1.
  - MEM_WAIT to RUN on dmem_ready.
  - MEM_WAIT stays put while !dmem_ready and wait_cnt<WAIT_MAX-1; wait_cnt increments.
  - MEM_WAIT to ERR on !dmem_ready with wait_cnt==WAIT_MAX-1.
  - ERR is left only by rst; mem_err=1 while in ERR.
- stall_cycles increments when StallF=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (async, immediate): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0. Combinational outputs then reflect the inputs under RUN.
- All stall, flush and forward outputs are same-cycle combinational (Mealy); registered state changes on the rising edge of clk.
- A memory access with N wait cycles asserts memStall for N cycles; the pipeline advances in the cycle dmem_ready=1.
- Timeout: with dmem_ready held low, ERR is entered on the WAIT_MAX-th stalled cycle edge. mem_err is visible the following cycle.
- dmem_ready=1 in the same cycle as MemReqM in RUN: no stall, state stays RUN.
- Reset asserted during MEM_WAIT or ERR: returns to RUN at once; a pending wait is abandoned.

## Structure
- Package hazard_pkg:
  - state enum {RUN, MEM_WAIT, ERR}.
  - forward constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One combinational sub-module, hazard_fwd_sel, instantiated twice (operand A and operand B). It takes RsE, RdM, RdW, RegWriteM and RegWriteW and returns the 2-bit select.
- FSM, wait_cnt (width $clog2(WAIT_MAX)), mem_err and stall_cycles are local to hazard_ctrl.

## Test plan
- Forwarding priority: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=RdM=RdW=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0. Set RdE=0 -> no stall.
- Branch: PCSrcE=1, MemReqM=0 -> FlushD=FlushE=1, StallF=0 for one cycle.
- Memory wait: MemReqM=1, dmem_ready low for 3 cycles then high -> StallF..StallM and FlushW high for exactly 3 cycles. stall_cycles=3. Concurrent PCSrcE flushes only in the 4th cycle.
- Timeout: WAIT_MAX=4, dmem_ready held 0 -> ERR after the 4th stalled cycle. mem_err=1 and all stalls remain 1 after dmem_ready rises.
- Reset mid-wait: assert rst during MEM_WAIT cycle 2 -> state RUN, mem_err=0, stall_cycles=0 immediately. Outputs follow inputs once rst is released.
